ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register; consumes everything the ID/EX register produces and feeds the MEM stage.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, runs the ALU, and registers results into EX/MEM.
- Contains an iterative shift-add multiplier (R-type funct 0x18). It stalls upstream through ex_busy while it runs.

Parameters:
- XLEN, 32, datapath width; also the multiplier iteration count.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_in  in  XLEN  PC of the instruction in EX
- alu_op  in  2  00 add, 01 sub, 10 R-type via funct, 11 slt signed
- alu_src  in  1  1 selects imm for ALU B
- funct  in  6  instruction bits 5:0
- rs_data, rt_data  in  XLEN  register file operands
- imm  in  XLEN  sign-extended immediate
- rs, rt, rd  in  5  register specifiers
- mem_read, mem_write, mem_to_reg, reg_write  in  1  control bits from ID/EX
- exm_rd  in  5, exm_reg_write  in  1, exm_result  in  XLEN  EX/MEM forwarding source
- mwb_rd  in  5, mwb_reg_write  in  1, mwb_data  in  XLEN  MEM/WB forwarding source
- pc_out  out  XLEN  registered PC
- alu_result  out  XLEN  registered result
- store_data  out  XLEN  registered forwarded rt value
- rd_out  out  5  registered destination register
- zero_out  out  1  registered (result == 0)
- mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out  out  1  registered control bits
- ex_busy  out  1  combinational stall: PC, IF/ID and ID/EX must hold while high

Behaviour:
- Forwarding, applied independently to rs and rt:
  - Use exm_result if exm_reg_write and exm_rd != 0 and exm_rd matches.
  - Else use mwb_data if mwb_reg_write and mwb_rd != 0 and mwb_rd matches.
  - Else use the register file value.
- ALU operands: A = forwarded rs. B = alu_src ? imm : forwarded rt. store_data = forwarded rt.
- R-type funct decode:
  - 0x20/0x21 add
  - 0x22/0x23 sub
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x18 mult
  - Any other funct gives result 0, with control bits passed through unchanged.
- Arithmetic is modulo 2^XLEN with no overflow trap. slt/sltu produce 1 or 0 zero-extended.
- Reset and bubble value for all registered outputs: pc_out = all ones; every other registered output = 0. ex_busy = 0 and FSM = IDLE on reset.
- Non-multiply latency: 1 cycle. Inputs present at edge N appear on the outputs after edge N.
- Multiplier FSM, states IDLE, MUL, DONE:
  - IDLE:
    - A multiply is present when alu_op = 10 and funct = 0x18.
    - In that case: ex_busy = 1; latch forwarded rs and rt as an unsigned multiplicand/multiplier; clear the accumulator; count = XLEN; EX/MEM loads a bubble; next state MUL.
    - Otherwise: normal pass-through.
  - MUL:
    - ex_busy = 1; EX/MEM loads a bubble each cycle.
    - Each cycle: if the multiplier LSB = 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement count.
    - When count reaches 0, next state DONE.
  - DONE:
    - ex_busy = 0. EX/MEM loads the low XLEN bits of the product, with the mult's pc, rd and control bits.
    - Next state IDLE unconditionally. Must not restart, even though ID/EX still shows the mult this cycle.
- ex_busy is high for exactly XLEN+1 consecutive cycles per multiply.
- Operands are captured only in IDLE. Forwarding-source changes during MUL have no effect.
- rst during MUL or DONE: FSM returns to IDLE, ex_busy drops the same cycle, outputs take reset values, and the partial product is discarded.
- Back-to-back multiplies: the second mult is seen in IDLE on the cycle after DONE and starts a new sequence.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: multiplier FSM present as specified above.
- Undefined: no FSM is built. funct 0x18 falls into the undefined-funct rule (result 0, single cycle), and ex_busy is tied to 0.

Test Plan:
- add, rs_data=5, rt_data=7, no forwarding -> next edge alu_result=12, zero_out=0, reg_write_out=1.
- sub with exm_rd=rs=3, exm_reg_write=1, exm_result=9, mwb_rd=3, mwb_data=1, rt_data=9 -> alu_result=0 (EX/MEM priority), zero_out=1.
- Forwarding suppressed when rd=0: exm_rd=0, rs=0, exm_result=0xDEAD, rs_data=0, addi imm=4 -> alu_result=4.
- slt with A=0xFFFFFFFF, B=1 -> 1; sltu with the same operands -> 0.
- mult A=0x0001_0003, B=0x0000_0005 (EX_MUL_EN defined) -> ex_busy high 33 cycles with bubbles (pc_out=0xFFFFFFFF) on EX/MEM, then alu_result=0x0005_000F.
- Assert rst on the 10th busy cycle of a mult -> next edge: ex_busy=0, all outputs at reset values, next instruction executes normally.

Source files
------------

// File: rtl/ex_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_stage_if : ID/EX inputs, forwarding sources and EX/MEM outputs |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ex_stage_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc_in;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic            reg_write;
  logic [4:0]      exm_rd;
  logic            exm_reg_write;
  logic [XLEN-1:0] exm_result;
  logic [4:0]      mwb_rd;
  logic            mwb_reg_write;
  logic [XLEN-1:0] mwb_data;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_out;
  logic            zero_out;
  logic            mem_read_out;
  logic            mem_write_out;
  logic            mem_to_reg_out;
  logic            reg_write_out;
  logic            ex_busy;

  modport master (
    output pc_in, alu_op, alu_src, funct, rs_data, rt_data, imm, rs, rt, rd,
           mem_read, mem_write, mem_to_reg, reg_write,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_data,
    input  pc_out, alu_result, store_data, rd_out, zero_out,
           mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, ex_busy
  );

  modport slave (
    input  pc_in, alu_op, alu_src, funct, rs_data, rt_data, imm, rs, rt, rd,
           mem_read, mem_write, mem_to_reg, reg_write,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_data,
    output pc_out, alu_result, store_data, rd_out, zero_out,
           mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, ex_busy
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_stage : forwarding, ALU and EX/MEM register; define EX_MUL_EN  |
// |            to build the iterative shift-add multiplier            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res_d;
  logic            mul_bubble;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] sd_q;
  logic [4:0]      rd_q;
  logic            zero_q;
  logic            mr_q;
  logic            mw_q;
  logic            m2r_q;
  logic            rw_q;

  // EX/MEM takes priority over MEM/WB since it holds the younger result.
  always_comb begin
    fwd_a = bus.rs_data;
    if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == bus.rs))
      fwd_a = bus.exm_result;
    else if (bus.mwb_reg_write && (bus.mwb_rd != 5'd0) && (bus.mwb_rd == bus.rs))
      fwd_a = bus.mwb_data;

    fwd_b = bus.rt_data;
    if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == bus.rt))
      fwd_b = bus.exm_result;
    else if (bus.mwb_reg_write && (bus.mwb_rd != 5'd0) && (bus.mwb_rd == bus.rt))
      fwd_b = bus.mwb_data;
  end

  assign alu_b = bus.alu_src ? bus.imm : fwd_b;

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b11: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      default: begin
        case (bus.funct)
          6'h20, 6'h21: alu_res = fwd_a + alu_b;
          6'h22, 6'h23: alu_res = fwd_a - alu_b;
          6'h24:        alu_res = fwd_a & alu_b;
          6'h25:        alu_res = fwd_a | alu_b;
          6'h26:        alu_res = fwd_a ^ alu_b;
          6'h27:        alu_res = ~(fwd_a | alu_b);
          6'h2A:        alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
          6'h2B:        alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
          default:      alu_res = '0;
        endcase
      end
    endcase
  end

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy;
  logic            mul_req;

  assign mul_req = (bus.alu_op == 2'b10) && (bus.funct == 6'h18);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    mul_bubble = 1'b0;
    mul_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_req) begin
          busy       = 1'b1;
          mul_bubble = 1'b1;
          mcand_d    = fwd_a;
          mplier_d   = fwd_b;
          acc_d      = '0;
          cnt_d      = CNT_W'(XLEN);
          state_d    = MUL;
        end
      end
      MUL: begin
        busy       = 1'b1;
        mul_bubble = 1'b1;
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        // ID/EX still shows the mult here; returning to IDLE without
        // looking at it is what prevents a spurious restart.
        mul_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_prod    = acc_q;
  assign bus.ex_busy = busy & ~rst;
`else
  assign mul_bubble  = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_prod    = '0;
  assign bus.ex_busy = 1'b0;
`endif

  assign res_d = mul_done ? mul_prod : alu_res;

  always_ff @(posedge clk) begin
    if (rst || mul_bubble) begin
      pc_q   <= '1;
      res_q  <= '0;
      sd_q   <= '0;
      rd_q   <= '0;
      zero_q <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
    end else begin
      pc_q   <= bus.pc_in;
      res_q  <= res_d;
      sd_q   <= fwd_b;
      rd_q   <= bus.rd;
      zero_q <= (res_d == '0);
      mr_q   <= bus.mem_read;
      mw_q   <= bus.mem_write;
      m2r_q  <= bus.mem_to_reg;
      rw_q   <= bus.reg_write;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.alu_result     = res_q;
  assign bus.store_data     = sd_q;
  assign bus.rd_out         = rd_q;
  assign bus.zero_out       = zero_q;
  assign bus.mem_read_out   = mr_q;
  assign bus.mem_write_out  = mw_q;
  assign bus.mem_to_reg_out = m2r_q;
  assign bus.reg_write_out  = rw_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ex_stage : randomized bench for ex_stage against a reference   |
// | model; multiply expectations follow EX_MUL_EN. Rev 1.0            |
// +------------------------------------------------------------------+
module tb_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(XLEN)) bus ();
  ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic        src;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  mwb_rd;
    logic        mwb_rw;
    logic [31:0] mwb_data;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        zero;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
  } out_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".pc_out"},     bus.pc_out,                 e.pc);
    check({tag, ".alu_result"}, bus.alu_result,             e.res);
    check({tag, ".store_data"}, bus.store_data,             e.sd);
    check({tag, ".rd_out"},     32'(bus.rd_out),            32'(e.rd));
    check({tag, ".zero_out"},   32'(bus.zero_out),          32'(e.zero));
    check({tag, ".ctrl"},
          32'({bus.mem_read_out, bus.mem_write_out, bus.mem_to_reg_out, bus.reg_write_out}),
          32'({e.mr, e.mw, e.m2r, e.rw}));
  endtask

  function automatic out_t bubble();
    out_t o = '0;
    o.pc = '1;
    return o;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf, input instr_t t);
    if (t.exm_rw && t.exm_rd != 0 && t.exm_rd == r) return t.exm_res;
    if (t.mwb_rw && t.mwb_rd != 0 && t.mwb_rd == r) return t.mwb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] rtv);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned prod = ua * 64'(rtv);
    if (op == 2'b00) return 32'(ua + ub);
    if (op == 2'b01) return 32'(ua - ub);
    if (op == 2'b11) return (sa < sb) ? 32'd1 : 32'd0;
    case (f)
      6'h20, 6'h21: return 32'(ua + ub);
      6'h22, 6'h23: return 32'(ua - ub);
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (ua < ub) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      6'h18: return 32'(prod);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic out_t ref_out(input instr_t t);
    out_t o;
    logic [31:0] a   = ref_fwd(t.rs, t.rs_data, t);
    logic [31:0] rtv = ref_fwd(t.rt, t.rt_data, t);
    logic [31:0] b   = t.src ? t.imm : rtv;
    o.pc   = t.pc;
    o.res  = ref_alu(t.op, t.funct, a, b, rtv);
    o.sd   = rtv;
    o.rd   = t.rd;
    o.zero = (o.res == 0);
    o.mr   = t.mr;
    o.mw   = t.mw;
    o.m2r  = t.m2r;
    o.rw   = t.rw;
    return o;
  endfunction

  task automatic drive(input instr_t t);
    bus.pc_in = t.pc;           bus.alu_op = t.op;         bus.alu_src = t.src;
    bus.funct = t.funct;        bus.rs_data = t.rs_data;   bus.rt_data = t.rt_data;
    bus.imm = t.imm;            bus.rs = t.rs;             bus.rt = t.rt;
    bus.rd = t.rd;              bus.mem_read = t.mr;       bus.mem_write = t.mw;
    bus.mem_to_reg = t.m2r;     bus.reg_write = t.rw;
    bus.exm_rd = t.exm_rd;      bus.exm_reg_write = t.exm_rw; bus.exm_result = t.exm_res;
    bus.mwb_rd = t.mwb_rd;      bus.mwb_reg_write = t.mwb_rw; bus.mwb_data = t.mwb_data;
  endtask

  // One cycle: present t, check the stall before the edge, outputs after it.
  task automatic step(input string tag, input instr_t t, input logic exp_busy, input out_t e);
    drive(t);
    #1;
    check({tag, ".ex_busy"}, 32'(bus.ex_busy), 32'(exp_busy));
    @(posedge clk);
    #1;
    check_out(tag, e);
  endtask

`ifdef EX_MUL_EN
  // ID/EX holds the mult while stalled; only forwarding sources wander.
  task automatic run_mult(input instr_t t, input int rst_at);
    instr_t w;
    step("mul_start", t, 1'b1, bubble());
    for (int k = 1; k <= XLEN; k++) begin
      w = t;
      if (k > 1 && k < XLEN) begin
        w.exm_res  = $urandom;
        w.mwb_data = $urandom;
      end
      if (k == rst_at) begin
        drive(w);
        rst = 1'b1;
        #1;
        check("mul_rst.ex_busy", 32'(bus.ex_busy), 32'd0);
        @(posedge clk);
        #1;
        check_out("mul_rst", bubble());
        rst = 1'b0;
        return;
      end
      step("mul_busy", w, 1'b1, bubble());
    end
    step("mul_done", t, 1'b0, ref_out(t));
  endtask
`endif

  task automatic run_instr(input string tag, input instr_t t);
`ifdef EX_MUL_EN
    if (t.op == 2'b10 && t.funct == 6'h18) run_mult(t, 0);
    else
`endif
    step(tag, t, 1'b0, ref_out(t));
  endtask

  function automatic instr_t blank(input logic [31:0] pc);
    instr_t t = '0;
    t.pc = pc;
    return t;
  endfunction

  logic [5:0] flist [16];
  initial begin
    flist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h18, 6'h18, 6'h00, 6'h3F, 6'h19, 6'h2C};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    logic [31:0] pc;

    rst = 1'b1;
    drive(blank(32'h0));
    repeat (2) @(posedge clk);
    #1;
    check("reset.ex_busy", 32'(bus.ex_busy), 32'd0);
    check_out("reset", bubble());
    rst = 1'b0;

    // add, no forwarding
    t = blank(32'h100); t.rs_data = 5; t.rt_data = 7; t.rs = 1; t.rt = 2; t.rd = 3; t.rw = 1;
    run_instr("add", t);
    check("add.lit", bus.alu_result, 32'd12);
    check("add.rw",  32'(bus.reg_write_out), 32'd1);

    // sub with both forwarding sources matching rs; EX/MEM wins
    t = blank(32'h104); t.op = 2'b01; t.rs = 3; t.rt = 4; t.rt_data = 9; t.rd = 5; t.rw = 1;
    t.exm_rd = 3; t.exm_rw = 1; t.exm_res = 9; t.mwb_rd = 3; t.mwb_rw = 1; t.mwb_data = 1;
    run_instr("sub_fwd", t);
    check("sub_fwd.lit",  bus.alu_result, 32'd0);
    check("sub_fwd.zero", 32'(bus.zero_out), 32'd1);

    // forwarding from register 0 is suppressed
    t = blank(32'h108); t.src = 1; t.imm = 4; t.rd = 6; t.rw = 1;
    t.exm_rd = 0; t.exm_rw = 1; t.exm_res = 32'hDEAD;
    run_instr("addi_r0", t);
    check("addi_r0.lit", bus.alu_result, 32'd4);

    // signed vs unsigned compare
    t = blank(32'h10C); t.op = 2'b11; t.rs_data = 32'hFFFF_FFFF; t.rt_data = 1; t.rs = 1; t.rt = 2;
    run_instr("slt", t);
    check("slt.lit", bus.alu_result, 32'd1);
    t.pc = 32'h110; t.op = 2'b10; t.funct = 6'h2B;
    run_instr("sltu", t);
    check("sltu.lit", bus.alu_result, 32'd0);

    // multiply, then a back-to-back pair
    t = blank(32'h114); t.op = 2'b10; t.funct = 6'h18; t.rs = 1; t.rt = 2; t.rd = 7; t.rw = 1;
    t.rs_data = 32'h0001_0003; t.rt_data = 32'h0000_0005;
    run_instr("mult", t);
`ifdef EX_MUL_EN
    check("mult.lit", bus.alu_result, 32'h0005_000F);
`else
    check("mult.lit", bus.alu_result, 32'h0);
`endif
    t.pc = 32'h118; t.rt_data = 32'h1234_5678;
    run_instr("mult_b2b1", t);
    t.pc = 32'h11C; t.rs_data = 32'hFFFF_FFFF;
    run_instr("mult_b2b2", t);

`ifdef EX_MUL_EN
    // reset during the tenth busy cycle, then normal execution resumes
    t.pc = 32'h120;
    run_mult(t, 9);
`endif
    t = blank(32'h124); t.rs_data = 32'h10; t.rt_data = 32'h20; t.rs = 1; t.rt = 2; t.rd = 8; t.rw = 1;
    run_instr("post_rst", t);

    pc = 32'h200;
    for (int i = 0; i < 300; i++) begin
      t = blank(pc);
      pc += 4;
      t.op      = 2'($urandom_range(0, 3));
      t.src     = (t.op == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
      t.funct   = flist[$urandom_range(0, 15)];
      t.rs_data = $urandom;
      t.rt_data = ($urandom_range(0, 3) == 0) ? t.rs_data : $urandom;
      t.imm     = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      t.rs      = 5'($urandom_range(0, 3));
      t.rt      = 5'($urandom_range(0, 3));
      t.rd      = 5'($urandom_range(0, 31));
      {t.mr, t.mw, t.m2r, t.rw} = 4'($urandom);
      t.exm_rd  = 5'($urandom_range(0, 3));
      t.exm_rw  = 1'($urandom);
      t.exm_res = $urandom;
      t.mwb_rd  = 5'($urandom_range(0, 3));
      t.mwb_rw  = 1'($urandom);
      t.mwb_data = $urandom;
      run_instr("rand", t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
